// File: rtl/oam_dma_pkg.sv
// Shared constants and types for the sprite DMA engine and the ppu register map.
package oam_dma_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
    localparam int          XFER_LEN     = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    // True when the snooped CPU cycle is a write to the given register.
    function automatic logic is_reg_write(input logic [15:0] addr,
                                          input logic        rw,
                                          input logic [15:0] reg_addr);
        return (addr == reg_addr) && (rw == 1'b0);
    endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: halts the CPU on a $4014 write and streams one page
// into OAMDATA as alternating bus reads and register writes.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = oam_dma_pkg::DMA_REG_ADDR,
    parameter logic [15:0] OAMDATA_ADDR = oam_dma_pkg::OAMDATA_ADDR,
    parameter int          XFER_LEN     = oam_dma_pkg::XFER_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr_i,
    input  logic        cpu_rw_i,
    input  logic [7:0]  cpu_data_i,
    input  logic [7:0]  bus_data_i,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic [15:0] bus_addr_o,
    output logic        bus_rw_o,
    output logic [7:0]  bus_data_o
);
    import oam_dma_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state_r;
    logic [7:0] page_r;
    logic [7:0] idx_r;
    logic       parity_r;
    logic [7:0] idx_nxt_s;

    assign idx_nxt_s = idx_r + 8'd1;

    // Cycle parity, transfer FSM and all registered bus outputs; everything advances only on cpu_ce.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            page_r     <= 8'h00;
            idx_r      <= 8'h00;
            parity_r   <= 1'b0;
            cpu_halt   <= 1'b0;
            dma_active <= 1'b0;
            bus_addr_o <= 16'h0000;
            bus_rw_o   <= 1'b1;
            bus_data_o <= 8'h00;
        end else if (cpu_ce) begin
            parity_r <= ~parity_r;
            case (state_r)
                IDLE: begin
                    if (is_reg_write(cpu_addr_i, cpu_rw_i, DMA_REG_ADDR)) begin
                        page_r   <= cpu_data_i;
                        idx_r    <= 8'h00;
                        cpu_halt <= 1'b1;
                        state_r  <= HALT;
                    end
                end
                // parity_r still holds the parity of the cycle now ending
                HALT: begin
                    if (parity_r) begin
                        dma_active <= 1'b1;
                        bus_rw_o   <= 1'b1;
                        bus_addr_o <= {page_r, idx_r};
                        state_r    <= READ;
                    end else begin
                        state_r    <= ALIGN;
                    end
                end
                ALIGN: begin
                    dma_active <= 1'b1;
                    bus_rw_o   <= 1'b1;
                    bus_addr_o <= {page_r, idx_r};
                    state_r    <= READ;
                end
                READ: begin
                    bus_data_o <= bus_data_i;
                    bus_rw_o   <= 1'b0;
                    bus_addr_o <= OAMDATA_ADDR;
                    state_r    <= WRITE;
                end
                WRITE: begin
                    if (idx_r == LAST_IDX) begin
                        cpu_halt   <= 1'b0;
                        dma_active <= 1'b0;
                        bus_rw_o   <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        idx_r      <= idx_nxt_s;
                        bus_rw_o   <= 1'b1;
                        bus_addr_o <= {page_r, idx_nxt_s};
                        state_r    <= READ;
                    end
                end
                default: begin
                    cpu_halt   <= 1'b0;
                    dma_active <= 1'b0;
                    bus_rw_o   <= 1'b1;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule
